// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDrain
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifq_if.sv
// Fetch queue bus: instruction memory handshake, datapath pop port and redirect.
// master is the fetch queue's view, slave is the memory/datapath side.
interface ifq_if;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output mem_req, mem_addr, instr_valid, instr, instr_pc,
      input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr, instr_pc,
      output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/ifq_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with flush and a combinational head read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: fetch PC, single-outstanding memory request FSM and
// instruction FIFO. Optional stall counter enabled by defining IFQ_STALL_COUNT_EN.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   ifq_if.master       bus
`ifdef IFQ_STALL_COUNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int unsigned   CW     = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fpc_q, fpc_d;
   logic [31:0]   drain_addr_q, drain_addr_d;
   logic          push, pop, flush, instr_valid;
   logic [CW-1:0] count, count_post_pop, count_after_push;
   logic [63:0]   head;

   assign instr_valid      = (count != '0);
   // A redirect flushes the FIFO, so a same-cycle pop is ignored.
   assign pop              = instr_valid & bus.instr_ready & ~bus.redirect;
   assign flush            = bus.redirect;
   assign count_post_pop   = count - CW'(pop);
   assign count_after_push = count_post_pop + CW'(1);

   always_comb begin
      state_d      = state_q;
      fpc_d        = fpc_q;
      drain_addr_d = drain_addr_q;
      push         = 1'b0;
      if (bus.redirect) fpc_d = bus.redirect_pc & ~32'h3;
      unique case (state_q)
         StIdle: begin
            if (bus.redirect || count_post_pop < DepthC) state_d = StReq;
         end
         StReq: begin
            if (bus.redirect) begin
               // Unacked request must still complete; its data is dropped in StDrain.
               if (!bus.mem_ack) begin
                  state_d      = StDrain;
                  drain_addr_d = fpc_q;
               end
            end else if (bus.mem_ack) begin
               push  = 1'b1;
               fpc_d = fpc_q + 32'd4;
               if (count_after_push >= DepthC) state_d = StIdle;
            end
         end
         StDrain: begin
            if (!bus.redirect && bus.mem_ack) state_d = StReq;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         fpc_q        <= RESET_PC;
         drain_addr_q <= RESET_PC;
      end else begin
         state_q      <= state_d;
         fpc_q        <= fpc_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i ({bus.mem_rdata, fpc_q}),
      .rdata_o (head),
      .count_o (count)
   );

   assign bus.mem_req     = (state_q != StIdle);
   assign bus.mem_addr    = (state_q == StDrain) ? drain_addr_q : fpc_q;
   assign bus.instr_valid = instr_valid;
   assign bus.instr       = instr_valid ? head[63:32] : NOP_INSTR;
   assign bus.instr_pc    = instr_valid ? head[31:0] : 32'h0;

`ifdef IFQ_STALL_COUNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (!instr_valid) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule
